vdec_tb_param: RTL and testbench

VDEC_TB_PARAM -- requirements
Module: vdec_tb_param

---
 rtl/vdec_tb_param.sv | 133 +++++++++++++
 tb/tb_vdec_tb_param.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vdec_tb_param.sv
// Viterbi traceback engine. It walks one block backwards through the survivor RAM,
// one stage per cycle, and streams out the decoded bits, last information bit first.
module vdec_tb_param #(
    parameter int ST_W    = 8,
    parameter int WORD_W  = 32,
    parameter int MAX_BLK = 64,
    localparam int WPS = (1 << ST_W) / WORD_W,
    localparam int SW  = $clog2(MAX_BLK + ST_W),
    localparam int AW  = SW + $clog2(WPS),
    localparam int BW  = $clog2(MAX_BLK + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               tail_mode,
    input  logic [ST_W-1:0]    start_state,
    input  logic [BW-1:0]      blk_size,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               out_valid,
    output logic               out_bit,
    output logic [MAX_BLK-1:0] dec_bits,
    output logic               pt_rd,
    output logic [AW-1:0]      pt_addr,
    input  logic [WORD_W-1:0]  pt_dout
);
    localparam int LW  = $clog2(WORD_W);
    localparam int WIW = AW - SW;
    localparam int SKW = $clog2(ST_W + 1);
    localparam logic [BW-1:0] MAX_B = BW'(MAX_BLK);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t             state_reg, state_next;
    logic [ST_W-1:0]    cur_state_reg;
    logic [SW-1:0]      stage_reg;
    logic [SKW-1:0]     skip_reg;
    logic               rd_q_reg;
    logic               err_reg;
    logic [MAX_BLK-1:0] dec_bits_reg;

    logic               blk_ok, accept, reject, d_bit;
    logic [ST_W-1:0]    pre_state, addr_state;
    logic [SW-1:0]      t_last;

    assign blk_ok = (blk_size != '0) && (blk_size <= MAX_B);
    assign accept = (state_reg == IDLE) && start && !abort && blk_ok;
    assign reject = (state_reg == IDLE) && start && !abort && !blk_ok;
    assign t_last = SW'(blk_size) + (tail_mode ? SW'(0) : SW'(ST_W)) - SW'(1);

    // Survivor bit for state j sits at word bit WORD_W-1-j, i.e. index ~j.
    generate
        if (LW > 0) begin : g_sel_word
            logic [LW-1:0] bit_idx;
            assign bit_idx = cur_state_reg[LW-1:0];
            assign d_bit   = pt_dout[~bit_idx];
        end else begin : g_sel_single
            assign d_bit = pt_dout[0];
        end
    endgenerate

    assign pre_state  = {d_bit, cur_state_reg[ST_W-1:1]};
    // Once returns are flowing, the next address comes straight from the predecessor.
    assign addr_state = rd_q_reg ? pre_state : cur_state_reg;

    assign pt_rd = (state_reg == RUN);
    generate
        if (WIW > 0) begin : g_addr_words
            assign pt_addr = pt_rd ? {stage_reg, addr_state[ST_W-1:LW]} : '0;
        end else begin : g_addr_stage
            assign pt_addr = pt_rd ? stage_reg : '0;
        end
    endgenerate

    assign busy      = (state_reg == RUN) || (state_reg == DRAIN);
    assign done      = (state_reg == FIN);
    assign err       = err_reg;
    assign out_valid = rd_q_reg && (skip_reg == '0);
    assign out_bit   = out_valid && pre_state[0];
    assign dec_bits  = dec_bits_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = RUN;
            RUN: begin
                if (abort)                 state_next = IDLE;
                else if (stage_reg == '0)  state_next = DRAIN;
            end
            DRAIN:   state_next = abort ? IDLE : FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cur_state_reg <= '0;
            stage_reg     <= '0;
            skip_reg      <= '0;
            rd_q_reg      <= 1'b0;
            err_reg       <= 1'b0;
            dec_bits_reg  <= '0;
        end else begin
            state_reg <= state_next;
            err_reg   <= reject;
            rd_q_reg  <= pt_rd && !abort;
            if (accept) begin
                cur_state_reg <= tail_mode ? start_state : '0;
                stage_reg     <= t_last;
                skip_reg      <= tail_mode ? SKW'(0) : SKW'(ST_W);
                dec_bits_reg  <= '0;
            end else if (busy && abort) begin
                skip_reg     <= '0;
                dec_bits_reg <= '0;
            end else begin
                if (pt_rd && (stage_reg != '0))
                    stage_reg <= stage_reg - SW'(1);
                if (rd_q_reg) begin
                    cur_state_reg <= pre_state;
                    // Zero-tail blocks drop the returns that belong to tail stages.
                    if (skip_reg != '0)
                        skip_reg <= skip_reg - SKW'(1);
                    else
                        dec_bits_reg <= {dec_bits_reg[MAX_BLK-2:0], pre_state[0]};
                end
            end
        end
    end
endmodule

// File: tb/tb_vdec_tb_param.sv
// Directed bench for vdec_tb_param: default instance plus ST_W=6/WORD_W=16/MAX_BLK=40,
// survivor RAMs filled by a forward reference encoder over a shifted state register.
module tb_vdec_tb_param;
    localparam int OFS = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, abort, tail_mode, sel_b;
    logic [7:0] start_state;
    logic [6:0] blk_size;

    logic        busy0, done0, err0, ov0, ob0, rd0;
    logic [63:0] dec0;
    logic [9:0]  addr0;
    logic [31:0] dout0;
    logic        busy1, done1, err1, ov1, ob1, rd1;
    logic [39:0] dec1;
    logic [7:0]  addr1;
    logic [15:0] dout1;

    int n_vec = 0;
    int n_err = 0;
    bit u [0:255];
    bit surv0 [0:127][0:255];
    bit surv1 [0:63][0:63];
    logic [63:0] last_exp;

    vdec_tb_param u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel_b), .abort(abort & ~sel_b),
        .tail_mode(tail_mode), .start_state(start_state), .blk_size(blk_size),
        .busy(busy0), .done(done0), .err(err0), .out_valid(ov0), .out_bit(ob0),
        .dec_bits(dec0), .pt_rd(rd0), .pt_addr(addr0), .pt_dout(dout0)
    );

    vdec_tb_param #(.ST_W(6), .WORD_W(16), .MAX_BLK(40)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start & sel_b), .abort(abort & sel_b),
        .tail_mode(tail_mode), .start_state(start_state[5:0]), .blk_size(blk_size[5:0]),
        .busy(busy1), .done(done1), .err(err1), .out_valid(ov1), .out_bit(ob1),
        .dec_bits(dec1), .pt_rd(rd1), .pt_addr(addr1), .pt_dout(dout1)
    );

    // Survivor RAM models: one-cycle registered read, MSB-first bit ordering.
    always @(posedge clk) begin
        if (rd0)
            for (int b = 0; b < 32; b++)
                dout0[31-b] <= surv0[addr0[9:3]][{addr0[2:0], 5'(b)}];
        if (rd1)
            for (int b = 0; b < 16; b++)
                dout1[15-b] <= surv1[addr1[7:2]][{addr1[1:0], 4'(b)}];
    end

    wire        busy_m  = sel_b ? busy1 : busy0;
    wire        done_m  = sel_b ? done1 : done0;
    wire        err_m   = sel_b ? err1  : err0;
    wire        ov_m    = sel_b ? ov1   : ov0;
    wire        ob_m    = sel_b ? ob1   : ob0;
    wire        rd_m    = sel_b ? rd1   : rd0;
    wire [63:0] dec_m   = sel_b ? {24'd0, dec1} : dec0;
    wire [6:0]  stage_m = sel_b ? {1'b0, addr1[7:2]} : addr0[9:3];
    wire [2:0]  idx_m   = sel_b ? {1'b0, addr1[1:0]} : addr0[2:0];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Forward encoder: state S[t] = last ST_W inputs ending at u[t]; survivor for stage t
    // at index S[t+1] holds the MSB of S[t]. Off-path entries are random.
    task automatic build(input bit s, input int n, input bit tm, input logic [7:0] ss);
        int stw, ns, tt, st;
        int sidx [0:255];
        stw = s ? 6 : 8;
        ns  = 1 << stw;
        tt  = n + (tm ? 0 : stw);
        for (int t = 0; t < tt; t++)
            for (int k = 0; k < ns; k++)
                if (s) surv1[t][k] = 1'($urandom);
                else   surv0[t][k] = 1'($urandom);
        for (int t = -OFS; t <= tt; t++)
            u[t+OFS] = (t < n) ? 1'($urandom) : 1'b0;
        if (tm)
            for (int k = 0; k < stw; k++) u[tt-k+OFS] = ss[k];
        st = 0;
        for (int t = -OFS; t <= tt; t++) begin
            st = ((st << 1) | int'(u[t+OFS])) & (ns - 1);
            sidx[t+OFS] = st;
        end
        for (int t = 0; t < tt; t++)
            if (s) surv1[t][sidx[t+1+OFS]] = 1'((sidx[t+OFS] >> (stw - 1)) & 1);
            else   surv0[t][sidx[t+1+OFS]] = 1'((sidx[t+OFS] >> (stw - 1)) & 1);
    endtask

    task automatic run_blk(input string tag, input bit s, input int n, input bit tm,
                           input logic [7:0] ss, input bit dup, input bit no_wait);
        int tt, rd_cnt, bad_stage, first_idx, ov_cnt, bad_bit, done_cyc, err_cnt;
        logic [63:0] exp_dec;
        tt = n + (tm ? 0 : (s ? 6 : 8));
        rd_cnt = 0; bad_stage = 0; first_idx = -1; ov_cnt = 0; bad_bit = 0;
        done_cyc = -1; err_cnt = 0;
        sel_b = s;
        build(s, n, tm, ss);
        exp_dec = '0;
        for (int i = 0; i < n; i++) exp_dec[i] = u[i+OFS];
        if (!no_wait) begin @(posedge clk); #1; end
        start = 1'b1; abort = 1'b0; blk_size = 7'(n); tail_mode = tm; start_state = ss;
        for (int c = 1; c <= tt + 10; c++) begin
            @(posedge clk); #1;
            start = dup && (c == 5);
            if (rd_m) begin
                rd_cnt++;
                if (int'(stage_m) != tt - rd_cnt || c != rd_cnt) bad_stage++;
                if (rd_cnt == 1) first_idx = int'(idx_m);
            end
            if (ov_m) begin
                if (ov_cnt >= n || ob_m != u[n-1-ov_cnt+OFS]) bad_bit++;
                ov_cnt++;
            end
            if (err_m) err_cnt++;
            if (done_m) begin done_cyc = c; break; end
        end
        start = 1'b0;
        chk({tag, "/reads"}, 64'(rd_cnt), 64'(tt));
        chk({tag, "/stage_seq"}, 64'(bad_stage), 64'd0);
        chk({tag, "/first_idx"}, 64'(first_idx), tm ? 64'(ss >> (s ? 4 : 5)) : 64'd0);
        chk({tag, "/nvalid"}, 64'(ov_cnt), 64'(n));
        chk({tag, "/stream_bits"}, 64'(bad_bit), 64'd0);
        chk({tag, "/done_cycle"}, 64'(done_cyc), 64'(tt + 2));
        chk({tag, "/dec_bits"}, dec_m, exp_dec);
        chk({tag, "/err"}, 64'(err_cnt), 64'd0);
        last_exp = exp_dec;
    endtask

    task automatic rej(input string tag, input int n, input bit ab, input int exp_err);
        int err1st, err_cnt, busy_cnt, rd_cnt;
        err1st = 0; err_cnt = 0; busy_cnt = 0; rd_cnt = 0;
        sel_b = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; abort = ab; blk_size = 7'(n); tail_mode = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            start = 1'b0; abort = 1'b0;
            if (err_m) begin err_cnt++; if (c == 1) err1st = 1; end
            if (busy_m) busy_cnt++;
            if (rd_m) rd_cnt++;
        end
        chk({tag, "/err_cycle1"}, 64'(err1st), 64'(exp_err));
        chk({tag, "/err_count"}, 64'(err_cnt), 64'(exp_err));
        chk({tag, "/busy_rd"}, 64'(busy_cnt + rd_cnt), 64'd0);
    endtask

    task automatic abort_then_start();
        logic [7:0] ss;
        ss = 8'($urandom);
        sel_b = 1'b0;
        build(1'b0, 29, 1'b1, ss);
        @(posedge clk); #1;
        start = 1'b1; blk_size = 7'd29; tail_mode = 1'b1; start_state = ss;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (c == 10) abort = 1'b1;
        end
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort/idle_outputs", {59'd0, busy_m, rd_m, ov_m, done_m, err_m}, 64'd0);
        chk("abort/dec_cleared", dec_m, 64'd0);
        run_blk("abort/next_blk", 1'b0, 29, 1'b0, 8'd0, 1'b0, 1'b1);
    endtask

    task automatic reset_mid_run();
        int late;
        logic [7:0] ss;
        late = 0;
        ss = 8'($urandom);
        sel_b = 1'b0;
        build(1'b0, 40, 1'b1, ss);
        @(posedge clk); #1;
        start = 1'b1; blk_size = 7'd40; tail_mode = 1'b1; start_state = ss;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("rst_mid/ctl", {58'd0, busy0, done0, err0, ov0, ob0, rd0}, 64'd0);
        chk("rst_mid/addr", 64'(addr0), 64'd0);
        chk("rst_mid/dec", dec0, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (done_m || ov_m || busy_m) late++;
        end
        chk("rst_mid/quiet_after", 64'(late), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; tail_mode = 1'b0; sel_b = 1'b0;
        start_state = '0; blk_size = '0; last_exp = '0;
        #12;
        chk("reset/ctl0", {58'd0, busy0, done0, err0, ov0, ob0, rd0}, 64'd0);
        chk("reset/addr_dec0", dec0 | 64'(addr0), 64'd0);
        chk("reset/ctl1", {58'd0, busy1, done1, err1, ov1, ob1, rd1}, 64'd0);
        chk("reset/addr_dec1", {24'd0, dec1} | 64'(addr1), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_blk("zt29", 1'b0, 29, 1'b0, 8'h00, 1'b0, 1'b0);
        run_blk("tr64_a5", 1'b0, 64, 1'b1, 8'hA5, 1'b0, 1'b0);
        run_blk("zt64", 1'b0, 64, 1'b0, 8'h00, 1'b0, 1'b0);
        run_blk("tr1", 1'b0, 1, 1'b1, 8'h3C, 1'b0, 1'b0);
        rej("size0", 0, 1'b0, 1);
        rej("size65", 65, 1'b0, 1);
        rej("abort_with_start", 10, 1'b1, 0);
        run_blk("dup_start", 1'b0, 29, 1'b0, 8'h00, 1'b1, 1'b0);
        abort_then_start();
        reset_mid_run();
        run_blk("p6_zt40", 1'b1, 40, 1'b0, 8'h00, 1'b0, 1'b0);
        run_blk("p6_tr17", 1'b1, 17, 1'b1, 8'h2B, 1'b0, 1'b0);
        run_blk("p6_zt23", 1'b1, 23, 1'b0, 8'h00, 1'b0, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("dec_hold", dec_m, last_exp);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
